// File: rtl/ctrl_pipe_pkg.sv
// Shared control-word definitions for the decode->execute control pipeline.
package ctrl_pipe_pkg;

    // Writeback source select
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // Memory access size; U variants zero-extend on load
    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_D  = 3'd3,
        SZ_BU = 3'd4,
        SZ_HU = 3'd5,
        SZ_WU = 3'd6
    } size_e;

    // Control payload carried by each pipeline entry, MSB first
    typedef struct packed {
        logic    reg_wr;
        logic    rd_en;
        logic    wr_en;
        size_e   size;
        wb_sel_e wb_sel;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline slot: valid bit plus payload, with load/clear/hold.
module ctrl_pipe_stage #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // Load wins over clear: a new entry may land in a slot whose old entry leaves or is killed
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Elastic control pipeline: DEPTH slots with ripple-back ready, per-stage
// flush and a registered occupancy count.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int               WIDTH  = CTRL_W,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_ctrl,
    output logic                       in_ready,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_ctrl,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] ctrl_q;
    logic [DEPTH:0]              ready;
    logic                        in_xfer;
    logic                        out_xfer;
    logic [OCC_W-1:0]            occ_next;

    // Ready ripples from the output back to stage 0; a killed slot counts as free
    always_comb begin
        logic r;
        r            = out_ready;
        ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r        = !vld_pipe[i] || flush[i] || r;
            ready[i] = r;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_ctrl;
        logic             load;
        logic             clear;

        if (i == 0) begin : g_head
            assign up_vld  = in_valid;
            assign up_ctrl = in_ctrl;
        end else begin : g_body
            // A flushed upstream entry never moves forward
            assign up_vld  = vld_pipe[i-1] && !flush[i-1];
            assign up_ctrl = ctrl_q[i-1];
        end

        assign load  = up_vld && ready[i];
        // Old entry goes away if killed here or taken by the next slot
        assign clear = vld_pipe[i] && (flush[i] || ready[i+1]);

        ctrl_pipe_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .clear (clear),
            .d     (up_ctrl),
            .valid (vld_pipe[i]),
            .q     (ctrl_q[i])
        );
    end

    assign in_ready  = ready[0];
    assign out_valid = vld_pipe[DEPTH-1] && !flush[DEPTH-1];
    assign out_ctrl  = out_valid ? ctrl_q[DEPTH-1] : BUBBLE;
    assign in_xfer   = in_valid && ready[0];
    assign out_xfer  = out_valid && out_ready;

    // Next occupancy: +1 in, -1 out, -1 per live slot killed
    always_comb begin
        int n;
        n = int'(occupancy) + int'(in_xfer) - int'(out_xfer);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_pipe[i] && flush[i]) n--;
        end
        occ_next = OCC_W'(n);
    end

    // Occupancy register
    always_ff @(posedge clk) begin
        if (reset) occupancy <= '0;
        else       occupancy <= occ_next;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe (DEPTH=2, WIDTH=8): directed scenarios
// followed by random traffic, checked against a slot-level reference model.
module tb_ctrl_pipe;

    localparam int DEPTH = 2;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_ctrl;
    logic             in_ready;
    logic [DEPTH-1:0] flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_ctrl;
    logic             out_ready;
    logic [1:0]       occupancy;

    always #5 clk = ~clk;

    ctrl_pipe #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BUBBLE (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ctrl  (out_ctrl),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    typedef struct {
        bit         ir;
        bit         ov;
        logic [7:0] oc;
        int         occ;
    } exp_t;

    exp_t       exp_q[$];      // per-cycle expected outputs
    logic [7:0] tag_val[$];    // payload of every accepted entry, by tag
    bit         tag_dead[$];   // entry was flushed
    int         acc_q[$];      // tags in acceptance order, awaiting emission
    int         slot[DEPTH];   // tag held by each stage, -1 = empty
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, predict outputs from the model, advance the model
    task automatic cyc(input bit rst, input bit iv, input logic [7:0] d,
                       input bit orr, input logic [DEPTH-1:0] fl);
        exp_t e;
        int   nxt[DEPTH];
        int   live;
        bit   room;
        reset     = rst;
        in_valid  = iv;
        in_ctrl   = d;
        out_ready = orr;
        flush     = fl;

        live = 0;
        foreach (slot[i]) if (slot[i] >= 0) live++;
        e.occ = live;
        e.ov  = (slot[DEPTH-1] >= 0) && !fl[DEPTH-1];
        e.oc  = e.ov ? tag_val[slot[DEPTH-1]] : 8'h00;

        // Entries advance into any slot that is vacant after the step; walk from the output
        foreach (nxt[i]) nxt[i] = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i == DEPTH - 1) room = orr;
            else                room = (nxt[i+1] < 0);
            if (slot[i] >= 0) begin
                if (fl[i])       tag_dead[slot[i]] = 1'b1;
                else if (room) begin
                    if (i < DEPTH - 1) nxt[i+1] = slot[i];
                end else         nxt[i] = slot[i];
            end
        end
        e.ir = (nxt[0] < 0);
        if (iv && e.ir) begin
            tag_val.push_back(d);
            tag_dead.push_back(1'b0);
            acc_q.push_back(tag_val.size() - 1);
            nxt[0] = tag_val.size() - 1;
        end
        if (rst) begin
            foreach (nxt[i]) nxt[i] = -1;
            acc_q.delete();
        end
        exp_q.push_back(e);
        slot = nxt;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle, and check emitted entries in order
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] want;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("in_ready",  32'(in_ready),  32'(e.ir));
            chk("out_valid", 32'(out_valid), 32'(e.ov));
            chk("out_ctrl",  32'(out_ctrl),  32'(e.oc));
            chk("occupancy", 32'(occupancy), e.occ);
            if (!reset && out_valid && out_ready) begin
                while (acc_q.size() != 0 && tag_dead[acc_q[0]]) void'(acc_q.pop_front());
                if (acc_q.size() != 0) want = 32'(tag_val[acc_q.pop_front()]);
                else                   want = 32'hFFFF_FFFF;
                chk("emit_order", 32'(out_ctrl), want);
            end
        end
    end

    initial begin
        int leftover;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        flush     = '0;
        foreach (slot[i]) slot[i] = -1;
        repeat (2) @(posedge clk);
        #1;

        // Streaming 0x11,0x22,0x33
        cyc(0, 1, 8'h11, 1, 2'b00);
        cyc(0, 1, 8'h22, 1, 2'b00);
        cyc(0, 1, 8'h33, 1, 2'b00);
        repeat (3) cyc(0, 0, 8'h00, 1, 2'b00);

        // Backpressure: fill, stall four cycles, release
        cyc(0, 1, 8'hA5, 0, 2'b00);
        cyc(0, 1, 8'h5A, 0, 2'b00);
        repeat (4) cyc(0, 1, 8'hEE, 0, 2'b00);
        repeat (3) cyc(0, 0, 8'h00, 1, 2'b00);

        // Flush stage 0 while a new entry enters it
        cyc(0, 1, 8'h01, 0, 2'b00);
        cyc(0, 1, 8'h02, 0, 2'b00);
        cyc(0, 1, 8'h03, 0, 2'b01);
        repeat (3) cyc(0, 0, 8'h00, 1, 2'b00);

        // Flush the last stage while it is presenting
        cyc(0, 1, 8'h7F, 1, 2'b00);
        cyc(0, 0, 8'h00, 1, 2'b00);
        cyc(0, 0, 8'h00, 1, 2'b10);
        repeat (2) cyc(0, 0, 8'h00, 1, 2'b00);

        // Reset with a full pipe
        cyc(0, 1, 8'hC1, 0, 2'b00);
        cyc(0, 1, 8'hC2, 0, 2'b00);
        cyc(1, 1, 8'hC3, 1, 2'b00);
        cyc(0, 0, 8'h00, 1, 2'b00);

        // Full pipe, one in and one out every cycle
        cyc(0, 1, 8'h40, 0, 2'b00);
        cyc(0, 1, 8'h41, 0, 2'b00);
        for (int k = 0; k < 8; k++) cyc(0, 1, 8'(8'h50 + k), 1, 2'b00);
        repeat (3) cyc(0, 0, 8'h00, 1, 2'b00);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(99) == 0,
                ($urandom % 4) != 0,
                8'($urandom),
                ($urandom % 3) != 0,
                {($urandom % 10) == 0, ($urandom % 10) == 0});
        end

        // Drain and confirm nothing live was left behind
        repeat (4) cyc(0, 0, 8'h00, 1, 2'b00);
        leftover = 0;
        foreach (acc_q[k]) if (!tag_dead[acc_q[k]]) leftover++;
        chk("leftover", leftover, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
